// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM DAC with shared period counter
//
// Converts NCH signed samples into PWM streams that share one counter.
// Samples are offset to unsigned duties with saturation, held in a shadow
// register via a valid/ready handshake, and swapped into the active duty
// only on a period boundary so a period is never cut short or stretched.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   data_in      NCH signed samples, channel k at [k*DATA_W +: DATA_W]
//   data_valid   all channels of data_in valid this cycle
//   data_ready   shadow register free (registered)
//   pwm_out      registered PWM outputs, one per channel
//   period_start one-cycle pulse on the first cycle of each PWM period
module pwm_multi #(
   parameter int CNT_W  = 10,
   parameter int DATA_W = 12,
   parameter int NCH    = 2,
   parameter int CENTER = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NCH*DATA_W-1:0] data_in,
   input  logic                  data_valid,
   output logic                  data_ready,
   output logic [NCH-1:0]        pwm_out,
   output logic                  period_start
);

   localparam logic [CNT_W-1:0]         CNT_MAX = '1;
   localparam logic signed [DATA_W:0]   MID     = (DATA_W+1)'(2**(CNT_W-1));
   localparam logic signed [DATA_W:0]   FULL    = (DATA_W+1)'(2**CNT_W - 1);

   logic [CNT_W-1:0]        cnt;
   logic                    dir_down;
   logic                    pending;
   logic [CNT_W-1:0]        shadow     [NCH];
   logic [CNT_W-1:0]        active     [NCH];
   logic [CNT_W-1:0]        active_nxt [NCH];
   logic [CNT_W-1:0]        duty_conv  [NCH];
   logic signed [DATA_W:0]  offs       [NCH];
   logic                    boundary;
   logic                    accept;
   logic                    load;
   logic                    pending_nxt;

   assign boundary = (cnt == '0);
   assign accept   = data_valid && data_ready;
   assign load     = boundary && pending;

   // data_ready is kept low during reset by its own register, so it is
   // never simply !pending; an accept and a load can never coincide.
   always_comb begin
      pending_nxt = pending;
      if (accept)
         pending_nxt = 1'b1;
      else if (load)
         pending_nxt = 1'b0;
   end

   // Signed-to-offset conversion: sign-extend one bit so the midscale
   // offset cannot overflow, then clamp to the counter range.
   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         offs[k] = signed'({data_in[k*DATA_W + DATA_W-1], data_in[k*DATA_W +: DATA_W]}) + MID;
         if (offs[k][DATA_W])
            duty_conv[k] = '0;
         else if (offs[k] > FULL)
            duty_conv[k] = CNT_MAX;
         else
            duty_conv[k] = offs[k][CNT_W-1:0];
      end
   end

   // The compare uses the duty that will be active after this edge, so the
   // new value is already visible on the period_start cycle.
   always_comb begin
      for (int k = 0; k < NCH; k++)
         active_nxt[k] = load ? shadow[k] : active[k];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt          <= '0;
         dir_down     <= 1'b0;
         pending      <= 1'b0;
         data_ready   <= 1'b0;
         pwm_out      <= '0;
         period_start <= 1'b0;
         for (int k = 0; k < NCH; k++) begin
            shadow[k] <= '0;
            active[k] <= '0;
         end
      end else begin
         if (CENTER != 0) begin
            // Triangle: 0..max up, max-1..1 down, back to 0 (boundary).
            if (!dir_down) begin
               if (cnt == CNT_MAX) begin
                  cnt      <= CNT_MAX - CNT_W'(1);
                  dir_down <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end else begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1))
                  dir_down <= 1'b0;
            end
         end else begin
            cnt      <= cnt + CNT_W'(1);
            dir_down <= 1'b0;
         end

         pending    <= pending_nxt;
         data_ready <= !pending_nxt;
         for (int k = 0; k < NCH; k++) begin
            if (accept)
               shadow[k] <= duty_conv[k];
            active[k]  <= active_nxt[k];
            pwm_out[k] <= (cnt < active_nxt[k]);
         end
         period_start <= boundary;
      end
   end

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - directed vector bench for pwm_multi (edge and centre instances)
module tb_pwm_multi;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] data_in, data_in_c;
   logic        data_valid, data_valid_c;
   logic        data_ready, data_ready_c;
   logic [1:0]  pwm, pwm_c;
   logic        ps, ps_c;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic signed [11:0] d0;
      logic signed [11:0] d1;
      int                 e0;
      int                 e1;
   } vec_t;

   vec_t vecs [6];

   always #5 clk = ~clk;

   pwm_multi #(.CNT_W(10), .DATA_W(12), .NCH(2), .CENTER(0)) dut_e (
      .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
      .data_ready(data_ready), .pwm_out(pwm), .period_start(ps)
   );

   pwm_multi #(.CNT_W(10), .DATA_W(12), .NCH(2), .CENTER(1)) dut_c (
      .clk(clk), .rst(rst), .data_in(data_in_c), .data_valid(data_valid_c),
      .data_ready(data_ready_c), .pwm_out(pwm_c), .period_start(ps_c)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic wait_ready(input bit cm, input string nm);
      int n = 0;
      while (!(cm ? data_ready_c : data_ready) && n < 5000) begin
         tick();
         n++;
      end
      check(nm, int'(cm ? data_ready_c : data_ready), 1);
   endtask

   task automatic apply(input bit cm, input logic signed [11:0] a0,
                        input logic signed [11:0] a1, input string nm);
      wait_ready(cm, $sformatf("%s_rdy_before", nm));
      if (cm) begin
         data_in_c    = {a1, a0};
         data_valid_c = 1'b1;
      end else begin
         data_in    = {a1, a0};
         data_valid = 1'b1;
      end
      tick();
      data_valid   = 1'b0;
      data_valid_c = 1'b0;
      check($sformatf("%s_rdy_fall", nm), int'(cm ? data_ready_c : data_ready), 0);
      wait_ready(cm, $sformatf("%s_rdy_rise", nm));
   endtask

   // Observes one full period starting at a period_start cycle and compares
   // every cycle against the counter model (sawtooth or triangle).
   task automatic measure(input bit cm, input int d0, input int d1, input string nm);
      int len = cm ? 2046 : 1024;
      int h0 = 0, h1 = 0, bad = 0, c;
      logic p0, p1, s;
      for (int i = 0; i < len; i++) begin
         c  = (i <= 1023) ? i : 2046 - i;
         p0 = cm ? pwm_c[0] : pwm[0];
         p1 = cm ? pwm_c[1] : pwm[1];
         s  = cm ? ps_c : ps;
         if (p0 != (c < d0)) bad++;
         if (p1 != (c < d1)) bad++;
         if (s != (i == 0)) bad++;
         h0 += int'(p0);
         h1 += int'(p1);
         tick();
      end
      check($sformatf("%s_high0", nm), h0, cm ? ((d0 == 0) ? 0 : 2*d0 - 1) : d0);
      check($sformatf("%s_high1", nm), h1, cm ? ((d1 == 0) ? 0 : 2*d1 - 1) : d1);
      check($sformatf("%s_shape", nm), bad, 0);
   endtask

   initial begin
      int n_low, bad, c;

      vecs[0] = '{12'sd0,    -12'sd256,  512,  256};
      vecs[1] = '{12'sd2047, -12'sd2048, 1023, 0};
      vecs[2] = '{12'sd511,  12'sd512,   1023, 1023};
      vecs[3] = '{-12'sd512, 12'sd511,   0,    1023};
      vecs[4] = '{-12'sd513, 12'sd100,   0,    612};
      vecs[5] = '{12'sd1,    -12'sd1,    513,  511};

      rst          = 1'b1;
      data_in      = '0;
      data_in_c    = '0;
      data_valid   = 1'b0;
      data_valid_c = 1'b0;

      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_pwm", int'(pwm), 0);
         check("rst_ps", int'(ps), 0);
         check("rst_ready", int'(data_ready), 0);
      end
      rst = 1'b0;
      tick();
      check("rel_ps", int'(ps), 1);
      check("rel_ready", int'(data_ready), 1);
      measure(1'b0, 0, 0, "rel_p0");
      measure(1'b0, 0, 0, "rel_p1");

      for (int v = 0; v < 6; v++) begin
         apply(1'b0, vecs[v].d0, vecs[v].d1, $sformatf("vec%0d", v));
         measure(1'b0, vecs[v].e0, vecs[v].e1, $sformatf("vec%0d", v));
      end

      // Handshake: accept at cnt=300, valid held with different data.
      apply(1'b0, 12'sd0, 12'sd0, "hs_pre");
      measure(1'b0, 512, 512, "hs_pre");
      for (int i = 0; i < 299; i++) tick();
      data_in    = {12'sd256, -12'sd256};
      data_valid = 1'b1;
      tick();
      data_in = {12'sd2047, 12'sd2047};
      n_low = 0;
      bad   = 0;
      while (!data_ready && n_low < 3000) begin
         c = 300 + n_low;
         if (pwm[0] != (c < 512)) bad++;
         if (pwm[1] != (c < 512)) bad++;
         tick();
         n_low++;
      end
      data_valid = 1'b0;
      check("hs_low_cycles", n_low, 724);
      check("hs_old_duty", bad, 0);
      check("hs_ps_at_rise", int'(ps), 1);
      measure(1'b0, 256, 768, "hs_new");

      // Boundary collision: accept sampled on the cnt==0 edge.
      for (int i = 0; i < 1023; i++) tick();
      data_in    = {12'sd300, -12'sd400};
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      check("col_ready_low", int'(data_ready), 0);
      measure(1'b0, 256, 768, "col_old");
      check("col_ready_rise", int'(data_ready), 1);
      measure(1'b0, 112, 812, "col_new");
      measure(1'b0, 112, 812, "col_rep");

      // Mid-period reset with a live duty.
      for (int i = 0; i < 100; i++) tick();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst2_pwm", int'(pwm), 0);
         check("rst2_ps", int'(ps), 0);
         check("rst2_ready", int'(data_ready), 0);
         check("rst2_ready_c", int'(data_ready_c), 0);
      end
      rst = 1'b0;
      tick();
      check("rel2_ps", int'(ps), 1);
      check("rel2_ready", int'(data_ready), 1);
      check("rel2_ps_c", int'(ps_c), 1);
      check("rel2_ready_c", int'(data_ready_c), 1);
      measure(1'b0, 0, 0, "rel2_p0");
      measure(1'b0, 0, 0, "rel2_p1");

      // Centre-aligned instance.
      apply(1'b1, -12'sd256, 12'sd0, "ctr1");
      measure(1'b1, 256, 512, "ctr1");
      apply(1'b1, -12'sd512, 12'sd2047, "ctr2");
      measure(1'b1, 0, 1023, "ctr2");
      measure(1'b1, 0, 1023, "ctr2_rep");

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Parametrised, multi-channel successor of the single-channel 1-bit PWM DAC in the SDR output path. It converts per-channel signed samples into PWM streams that share one period counter. New capabilities: configurable resolution, signed-to-offset conversion with saturation, a valid/ready sample handshake with glitch-free period-boundary updates, and an optional centre-aligned mode. It sits between the demodulator/decimator output and the board pins that drive the RC-filtered audio outputs.

## Interface
- CNT_W, 10, counter/duty resolution in bits; nominal period 2^CNT_W clocks.
- DATA_W, 12, sample width, signed two's complement; DATA_W ≥ CNT_W.
- NCH, 2, number of PWM channels.
- CENTER, 0, 0 = edge-aligned sawtooth, 1 = centre-aligned triangle.
- clk  in  1  single clock; everything is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  NCH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- data_valid  in  1  all channels of data_in are valid this cycle.
- data_ready  out  1  shadow register can accept a sample set.
- pwm_out  out  NCH  registered PWM outputs.
- period_start  out  1  one-cycle pulse marking the first cycle of each period on pwm_out.

## Operation
- Counter cnt, CNT_W bits. Edge mode: 0,1,…,2^CNT_W−1, wraps to 0. Centre mode: counts up 0→2^CNT_W−1, then down to 1, then 0 again; period 2^(CNT_W+1)−2. Direction flag is internal.
- Boundary: the cycle in which cnt==0.
- Conversion per channel: duty = data + 2^(CNT_W−1), computed at DATA_W+1 bits signed, then saturated to [0, 2^CNT_W−1]. 0 → midscale; large positive → all-ones; large negative → 0.
- Shadow: accepted when data_valid && data_ready. All NCH converted duties are stored and pending is set. data_ready = !pending && !rst.
- Active duty: on a boundary with pending=1, active ← shadow and pending clears. With pending=0, active holds its previous value; the last sample repeats.
- Simultaneous: data_ready is low whenever pending=1, so no accept can coincide with a pending transfer. An accept in the boundary cycle with pending=0 only loads the shadow; it takes effect at the next boundary.
- Compare: pwm_out[k] ← (cnt < active[k]). Duty 0 gives constant low. Duty 2^CNT_W−1 gives high for all but one count per sawtooth.
- period_start ← (cnt==0), registered in the same stage as pwm_out so the two are aligned.
- Reset (sync, any time including mid-period):
  - cnt=0, direction=up.
  - active=0, shadow=0, pending=0.
  - pwm_out=0, period_start=0, data_ready=0.
  - The first cycle after rst deasserts is a boundary.

## Timing
- pwm_out and period_start lag cnt by exactly 1 clock.
- Sample accepted in cycle t: appears on pwm_out at the first period_start after the next boundary ≥ t+1. Maximum latency is one period + 1 clock.
- data_ready falls the cycle after an accept. It rises the cycle after the boundary that consumes the shadow.
- Edge mode: high time = active clocks per 2^CNT_W. Centre mode: high time = 2·active−1 clocks (0 if active=0), centred on cnt=0.
- No combinational path from any input to any output.

## Test plan
- Reset (CNT_W=10, DATA_W=12, NCH=2): hold rst 3 cycles mid-period → pwm_out=00, period_start=0, data_ready=0 during rst. data_ready=1 the cycle after release. First period_start 1 cycle after release, then every 1024 cycles.
- Midscale/linearity: ch0=0, ch1=−256 accepted → from the next period_start, ch0 high 512/1024 and ch1 high 256/1024 cycles, both starting at period_start.
- Saturation: ch0=+2047, ch1=−2048 → ch0 high 1023/1024, ch1 constant 0. Then ch0=+511 → 1023/1024, ch0=−512 → constant 0.
- Handshake: accept at cnt=300 → data_ready=0 until 1 cycle after the next cnt=0. A data_valid held high across the interval is not accepted early. The output changes only at the period_start following the boundary.
- Boundary collision: data_valid with pending=0 exactly at cnt=0 → current period keeps the old duty, new duty applies one full period later. With no further writes, the duty repeats indefinitely.
- Centre mode (CENTER=1): ch0=−256 (duty 256) → period 2046 clocks, high 511 clocks symmetric about period_start. ch0=−512 → constant 0.
